// File: rtl/key_load_ctrl.sv
// Serial key loader for the locked c880 netlist.
// A key is shifted in key_0 first, followed by one even-parity bit. The
// shadow register is copied to key_out only after the parity check, so the
// netlist never sees a partially loaded key. Timeouts and parity failures
// raise a sticky err flag and leave the last committed key untouched.
module key_load_ctrl #(
  parameter int KEY_W   = 20,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_start,
  input  logic             key_valid,
  input  logic             key_sin,
  input  logic             key_clear,
  output logic [KEY_W-1:0] key_out,
  output logic             key_loaded,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam logic [4:0] LAST_BIT = 5'(KEY_W - 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [7:0]       tmo_q, tmo_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             loaded_q, loaded_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             tmo_hit;

  assign tmo_hit = (tmo_q == TMO_LAST);

  // Next-state logic: clear beats start, start restarts any load except a
  // commit in progress, and idle cycles in SHIFT/PARITY count toward abort.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shadow_d  = shadow_q;
    tmo_d     = tmo_q;
    key_d     = key_q;
    loaded_d  = loaded_q;
    err_d     = err_q;

    if (key_clear) begin
      state_d   = IDLE;
      key_d     = '0;
      loaded_d  = 1'b0;
      bit_cnt_d = '0;
      tmo_d     = '0;
    end else if (key_start && (state_q != COMMIT)) begin
      state_d   = SHIFT;
      bit_cnt_d = '0;
      shadow_d  = '0;
      tmo_d     = '0;
      err_d     = 1'b0;
    end else begin
      case (state_q)
        SHIFT: begin
          if (key_valid) begin
            shadow_d[bit_cnt_q] = key_sin;
            bit_cnt_d           = bit_cnt_q + 5'd1;
            tmo_d               = '0;
            if (bit_cnt_q == LAST_BIT) begin
              state_d = PARITY;
            end
          end else if (tmo_hit) begin
            err_d   = 1'b1;
            state_d = IDLE;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end
        PARITY: begin
          if (key_valid) begin
            tmo_d = '0;
            if ((^shadow_q ^ key_sin) == 1'b0) begin
              state_d = COMMIT;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end else if (tmo_hit) begin
            err_d   = 1'b1;
            state_d = IDLE;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end
        COMMIT: begin
          key_d    = shadow_q;
          loaded_d = 1'b1;
          state_d  = IDLE;
        end
        default: begin
        end
      endcase
    end

    busy_d = (state_d == SHIFT) || (state_d == PARITY);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shadow_q  <= '0;
      tmo_q     <= '0;
      key_q     <= '0;
      loaded_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shadow_q  <= shadow_d;
      tmo_q     <= tmo_d;
      key_q     <= key_d;
      loaded_q  <= loaded_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign key_out    = key_q;
  assign key_loaded = loaded_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_key_load_ctrl.sv
// Testbench for key_load_ctrl: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level reference model.
module tb_key_load_ctrl;

  localparam int KW  = 20;
  localparam int TMO = 255;

  logic          clk;
  logic          rst_n;
  logic          key_start;
  logic          key_valid;
  logic          key_sin;
  logic          key_clear;
  logic [KW-1:0] key_out;
  logic          key_loaded;
  logic          busy;
  logic          err;

  int testCount;
  int failCount;
  int busyCount;

  // Reference model: a load is a list of received bits; the key value and
  // parity are computed arithmetically from that list.
  bit            mRunning;
  bit            mCommit;
  int            mBits[$];
  int            mIdle;
  logic [KW-1:0] mPending;
  logic [KW-1:0] mKey;
  bit            mLoaded;
  bit            mErr;

  key_load_ctrl #(.KEY_W(KW), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_start (key_start),
    .key_valid (key_valid),
    .key_sin   (key_sin),
    .key_clear (key_clear),
    .key_out   (key_out),
    .key_loaded(key_loaded),
    .busy      (busy),
    .err       (err)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advances the reference model by one clock edge given this cycle's inputs.
  task automatic modelStep(input bit rstV, input bit startV, input bit validV,
                           input bit sinV, input bit clrV);
    int ones;
    if (!rstV) begin
      mRunning = 0; mCommit = 0; mBits.delete(); mIdle = 0;
      mKey = '0; mLoaded = 0; mErr = 0; mPending = '0;
    end else if (clrV) begin
      mRunning = 0; mCommit = 0; mIdle = 0;
      mKey = '0; mLoaded = 0;
    end else if (mCommit) begin
      mKey = mPending; mLoaded = 1; mCommit = 0;
    end else if (startV) begin
      mRunning = 1; mBits.delete(); mIdle = 0; mErr = 0;
    end else if (mRunning) begin
      if (validV) begin
        mIdle = 0;
        if (mBits.size() < KW) begin
          mBits.push_back(int'(sinV));
        end else begin
          ones = int'(sinV);
          foreach (mBits[i]) ones += mBits[i];
          mRunning = 0;
          if (ones % 2 == 0) begin
            mPending = '0;
            foreach (mBits[i]) mPending[i] = mBits[i][0];
            mCommit = 1;
          end else begin
            mErr = 1;
          end
        end
      end else begin
        mIdle++;
        if (mIdle >= TMO) begin
          mErr = 1; mRunning = 0; mIdle = 0;
        end
      end
    end
  endtask

  // Drives one cycle of inputs, steps the model, and checks all outputs
  // one time unit after the rising edge.
  task automatic applyStimulus(input bit rstV, input bit startV, input bit validV,
                               input bit sinV, input bit clrV);
    rst_n = rstV; key_start = startV; key_valid = validV;
    key_sin = sinV; key_clear = clrV;
    modelStep(rstV, startV, validV, sinV, clrV);
    @(posedge clk);
    #1;
    if (busy === 1'b1) busyCount++;
    checkOutput("key_out", 32'(key_out), 32'(mKey));
    checkOutput("key_loaded", 32'(key_loaded), 32'(mLoaded));
    checkOutput("busy", 32'(busy), 32'(mRunning));
    checkOutput("err", 32'(err), 32'(mErr));
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Start pulse, all key bits contiguously (key_0 first), then the parity bit.
  task automatic loadKey(input logic [KW-1:0] key, input bit par);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < KW; i++) applyStimulus(1'b1, 1'b0, 1'b1, key[i], 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, par, 1'b0);
  endtask

  // Directed scenarios first, then randomized traffic, then the summary.
  initial begin
    logic [KW-1:0] rk;
    testCount = 0; failCount = 0; busyCount = 0;
    rst_n = 1'b0; key_start = 1'b0; key_valid = 1'b0; key_sin = 1'b0; key_clear = 1'b0;

    doReset();
    checkOutput("reset_key", 32'(key_out), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);

    busyCount = 0;
    loadKey(20'hA5C3F, 1'b0);
    checkOutput("lat_not_yet", 32'(key_loaded), 32'h0);
    idleCycles(1);
    checkOutput("good_key", 32'(key_out), 32'hA5C3F);
    checkOutput("good_loaded", 32'(key_loaded), 32'h1);
    checkOutput("busy_cycles", 32'(busyCount), 32'd21);

    doReset();
    loadKey(20'hA5C3F, 1'b1);
    idleCycles(1);
    checkOutput("par_err", 32'(err), 32'h1);
    checkOutput("par_key", 32'(key_out), 32'h0);
    checkOutput("par_loaded", 32'(key_loaded), 32'h0);
    checkOutput("par_busy", 32'(busy), 32'h0);

    doReset();
    loadKey(20'h12345, 1'b1);
    idleCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idleCycles(254);
    checkOutput("tmo_not_yet", 32'(err), 32'h0);
    idleCycles(1);
    checkOutput("tmo_err", 32'(err), 32'h1);
    checkOutput("tmo_key", 32'(key_out), 32'h12345);
    checkOutput("tmo_loaded", 32'(key_loaded), 32'h1);
    checkOutput("tmo_busy", 32'(busy), 32'h0);

    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    loadKey(20'h00001, 1'b1);
    idleCycles(1);
    checkOutput("restart_key", 32'(key_out), 32'h00001);
    checkOutput("restart_err", 32'(err), 32'h0);

    doReset();
    loadKey(20'hFFFFF, 1'b0);
    idleCycles(1);
    checkOutput("ones_key", 32'(key_out), 32'hFFFFF);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_key", 32'(key_out), 32'h0);
    checkOutput("clr_loaded", 32'(key_loaded), 32'h0);
    checkOutput("clr_busy", 32'(busy), 32'h0);

    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    checkOutput("midrst_key", 32'(key_out), 32'h0);
    loadKey(20'hA5C3F, 1'b0);
    idleCycles(1);
    checkOutput("midrst_reload", 32'(key_out), 32'hA5C3F);

    for (int n = 0; n < 20; n++) begin
      rk = KW'($urandom);
      loadKey(rk, 1'($urandom_range(0, 1)));
      idleCycles($urandom_range(1, 4));
    end

    for (int n = 0; n < 4000; n++) begin
      applyStimulus($urandom_range(0, 499) != 0, $urandom_range(0, 59) == 0,
                    $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 149) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
